// File: rtl/lcd_ycbcr_pkg.sv
// Shared constants for the LCD YCbCr tap.
// Holds the BT.601 full-range integer coefficients (scaled by 256), the
// rounding and chroma offset constants, the signed intermediate width used
// by the product/sum pipeline stages, the frame marker sideband type and the
// output clamp helper.
package lcd_ycbcr_pkg;

    // Component width the coefficients below are defined for.
    localparam int PIX_W = 8;

    // Signed intermediate width of the products and sums. The widest value
    // is 255*256+128 = 65408, and the most negative is about -32640, so 18
    // signed bits are enough.
    localparam int IW = 18;

    localparam logic signed [IW-1:0] C_YR  =  18'sd77;
    localparam logic signed [IW-1:0] C_YG  =  18'sd150;
    localparam logic signed [IW-1:0] C_YB  =  18'sd29;
    localparam logic signed [IW-1:0] C_CBR = -18'sd43;
    localparam logic signed [IW-1:0] C_CBG = -18'sd85;
    localparam logic signed [IW-1:0] C_CBB =  18'sd128;
    localparam logic signed [IW-1:0] C_CRR =  18'sd128;
    localparam logic signed [IW-1:0] C_CRG = -18'sd107;
    localparam logic signed [IW-1:0] C_CRB = -18'sd21;

    localparam logic signed [IW-1:0] ROUND  = 18'sd128;
    localparam logic signed [IW-1:0] OFFSET = 18'sd128;

    // Frame position markers carried alongside each beat.
    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } marker_t;

    // Saturate a signed intermediate into the unsigned 8-bit output range.
    function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [IW-1:0] v);
        logic [PIX_W-1:0] r;
        if (v < 18'sd0) begin
            r = '0;
        end else if (v > 18'sd255) begin
            r = '1;
        end else begin
            r = v[PIX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/rgb2ycbcr_px.sv
// Single-pixel RGB -> YCbCr converter, 3-stage pipeline.
//   S1: nine coefficient products
//   S2: three sums plus rounding constant
//   S3: arithmetic shift by 8, chroma offset, clamp to [0,255]
// Ports:
//   clk, srst      clock and synchronous active-high reset (clears all flops)
//   clr            clears the valid pipeline only (frame abort)
//   valid_i        input pixel valid
//   r_i, g_i, b_i  input components
//   valid_o        output valid, exactly 3 cycles after valid_i
//   y_o, cb_o, cr_o  converted components
module rgb2ycbcr_px
    import lcd_ycbcr_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             valid_i,
    input  logic [PIX_W-1:0] r_i,
    input  logic [PIX_W-1:0] g_i,
    input  logic [PIX_W-1:0] b_i,
    output logic             valid_o,
    output logic [PIX_W-1:0] y_o,
    output logic [PIX_W-1:0] cb_o,
    output logic [PIX_W-1:0] cr_o
);

    // Product k uses component k%3 (R,G,B) and coefficient k, grouped as
    // Y (0..2), Cb (3..5), Cr (6..8).
    localparam logic signed [IW-1:0] COEF [9] = '{
        C_YR,  C_YG,  C_YB,
        C_CBR, C_CBG, C_CBB,
        C_CRR, C_CRG, C_CRB
    };

    logic signed [IW-1:0] comp [3];
    logic signed [IW-1:0] prod_d [9];
    logic signed [IW-1:0] prod_q [9];
    logic signed [IW-1:0] sum_d  [3];
    logic signed [IW-1:0] sum_q  [3];
    logic [PIX_W-1:0]     res_d  [3];
    logic [PIX_W-1:0]     res_q  [3];
    logic [2:0]           v_d;
    logic [2:0]           v_q;

    // Components are unsigned; zero-extend before the signed multiply.
    always_comb begin
        comp[0] = $signed(IW'(r_i));
        comp[1] = $signed(IW'(g_i));
        comp[2] = $signed(IW'(b_i));
    end

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_prod
            always_comb begin
                prod_d[gi] = comp[gi % 3] * COEF[gi];
            end
        end

        for (genvar gi = 0; gi < 3; gi++) begin : g_out
            // Luma has no offset; both chroma channels are centred on 128.
            localparam logic signed [IW-1:0] OFS = (gi == 0) ? 18'sd0 : OFFSET;
            logic signed [IW-1:0] shifted;

            always_comb begin
                sum_d[gi] = prod_q[3*gi] + prod_q[3*gi+1] + prod_q[3*gi+2] + ROUND;
            end

            always_comb begin
                shifted   = (sum_q[gi] >>> 8) + OFS;
                res_d[gi] = clamp_pix(shifted);
            end
        end
    endgenerate

    always_comb begin
        v_d = {v_q[1:0], valid_i};
        if (clr) begin
            v_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            v_q <= '0;
            for (int i = 0; i < 9; i++) prod_q[i] <= '0;
            for (int i = 0; i < 3; i++) begin
                sum_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
            for (int i = 0; i < 3; i++) begin
                sum_q[i] <= sum_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end

    assign valid_o = v_q[2];
    assign y_o     = res_q[0];
    assign cb_o    = res_q[1];
    assign cr_o    = res_q[2];

endmodule

// File: rtl/lcd_ycbcr_tap.sv
// LCD output stream tap: converts each RGB pixel pair to YCbCr (two
// rgb2ycbcr_px lanes), tags beats with sof/eol/eof and counts frames.
// Ports:
//   HCLK, HRESET        clock, synchronous active-high reset
//   clr                 frame abort: clears position, busy, valids, sideband
//   cfg_width/height    frame geometry, latched at the first beat of a frame
//   in_valid, in_*      incoming pixel pair (pixel 0 left, pixel 1 right)
//   out_valid, out_*    YCbCr pair, 3 cycles after its input beat
//   out_sof/eol/eof     position markers, valid with out_valid
//   frame_done          pulse on the out_eof beat
//   frame_cnt           completed frames (wrapping)
module lcd_ycbcr_tap
    import lcd_ycbcr_pkg::*;
#(
    parameter int IMG_PIX_W = 8,
    parameter int W_SIZE    = 12,
    parameter int W_FCNT    = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 clr,
    input  logic [W_SIZE-1:0]    cfg_width,
    input  logic [W_SIZE-1:0]    cfg_height,
    input  logic                 in_valid,
    input  logic [IMG_PIX_W-1:0] in_r0,
    input  logic [IMG_PIX_W-1:0] in_g0,
    input  logic [IMG_PIX_W-1:0] in_b0,
    input  logic [IMG_PIX_W-1:0] in_r1,
    input  logic [IMG_PIX_W-1:0] in_g1,
    input  logic [IMG_PIX_W-1:0] in_b1,
    output logic                 out_valid,
    output logic [IMG_PIX_W-1:0] out_y0,
    output logic [IMG_PIX_W-1:0] out_cb0,
    output logic [IMG_PIX_W-1:0] out_cr0,
    output logic [IMG_PIX_W-1:0] out_y1,
    output logic [IMG_PIX_W-1:0] out_cb1,
    output logic [IMG_PIX_W-1:0] out_cr1,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_eof,
    output logic                 frame_done,
    output logic [W_FCNT-1:0]    frame_cnt
);

    logic              accept;
    logic              lane0_valid;
    logic              lane1_valid;

    logic              busy_d, busy_q;
    logic [W_SIZE-1:0] x_d, x_q;
    logic [W_SIZE-1:0] y_d, y_q;
    logic [W_SIZE-1:0] w_d, w_q;
    logic [W_SIZE-1:0] h_d, h_q;
    logic [W_SIZE-1:0] w_eff;
    logic [W_SIZE-1:0] h_eff;
    marker_t           mk;
    marker_t           sb_d [3];
    marker_t           sb_q [3];
    logic [W_FCNT-1:0] frame_cnt_d, frame_cnt_q;

    // A beat coinciding with clr is dropped.
    assign accept = in_valid & ~clr;

    rgb2ycbcr_px u_lane0 (
        .clk     (HCLK),
        .srst    (HRESET),
        .clr     (clr),
        .valid_i (accept),
        .r_i     (in_r0),
        .g_i     (in_g0),
        .b_i     (in_b0),
        .valid_o (lane0_valid),
        .y_o     (out_y0),
        .cb_o    (out_cb0),
        .cr_o    (out_cr0)
    );

    rgb2ycbcr_px u_lane1 (
        .clk     (HCLK),
        .srst    (HRESET),
        .clr     (clr),
        .valid_i (accept),
        .r_i     (in_r1),
        .g_i     (in_g1),
        .b_i     (in_b1),
        .valid_o (lane1_valid),
        .y_o     (out_y1),
        .cb_o    (out_cb1),
        .cr_o    (out_cr1)
    );

    always_comb begin
        // The first beat of a frame sees the live config; later beats use
        // the latched copy. Width bit 0 is ignored (pairs only).
        w_eff = busy_q ? w_q : (cfg_width & ~W_SIZE'(1));
        h_eff = busy_q ? h_q : cfg_height;

        mk.sof = ~busy_q;
        mk.eol = ((x_q + W_SIZE'(2)) == w_eff);
        mk.eof = mk.eol && ((y_q + W_SIZE'(1)) == h_eff);

        busy_d = busy_q;
        x_d    = x_q;
        y_d    = y_q;
        w_d    = w_q;
        h_d    = h_q;

        if (accept) begin
            if (!busy_q) begin
                w_d    = w_eff;
                h_d    = h_eff;
                busy_d = 1'b1;
            end
            // eof overrides the capture above so a single-beat frame
            // leaves busy clear.
            if (mk.eof) begin
                x_d    = '0;
                y_d    = '0;
                busy_d = 1'b0;
            end else if (mk.eol) begin
                x_d = '0;
                y_d = y_q + W_SIZE'(1);
            end else begin
                x_d = x_q + W_SIZE'(2);
            end
        end

        if (clr) begin
            x_d    = '0;
            y_d    = '0;
            busy_d = 1'b0;
        end

        // Sideband delay line, aligned with the datapath stages.
        sb_d[0] = accept ? mk : '0;
        sb_d[1] = sb_q[0];
        sb_d[2] = sb_q[1];
        if (clr) begin
            sb_d[0] = '0;
            sb_d[1] = '0;
            sb_d[2] = '0;
        end

        // Count on the edge that moves eof into the output stage so the
        // new count is visible together with frame_done.
        frame_cnt_d = frame_cnt_q;
        if (sb_d[2].eof) begin
            frame_cnt_d = frame_cnt_q + W_FCNT'(1);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            busy_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            frame_cnt_q <= '0;
            for (int i = 0; i < 3; i++) sb_q[i] <= '0;
        end else begin
            busy_q      <= busy_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            frame_cnt_q <= frame_cnt_d;
            for (int i = 0; i < 3; i++) sb_q[i] <= sb_d[i];
        end
    end

    assign out_valid  = lane0_valid & lane1_valid;
    assign out_sof    = sb_q[2].sof;
    assign out_eol    = sb_q[2].eol;
    assign out_eof    = sb_q[2].eof;
    assign frame_done = sb_q[2].eof;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_lcd_ycbcr_tap.sv
// Directed testbench for lcd_ycbcr_tap: reset, colour corners, markers,
// gaps with config change, clr abort and frame counter wrap.
module tb_lcd_ycbcr_tap;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        clr;
    logic [11:0] cfg_width;
    logic [11:0] cfg_height;
    logic        in_valid;
    logic [7:0]  in_r0, in_g0, in_b0, in_r1, in_g1, in_b1;
    logic        out_valid;
    logic [7:0]  out_y0, out_cb0, out_cr0, out_y1, out_cb1, out_cr1;
    logic        out_sof, out_eol, out_eof, frame_done;
    logic [15:0] frame_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 HCLK = ~HCLK;

    lcd_ycbcr_tap dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .clr        (clr),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .in_valid   (in_valid),
        .in_r0      (in_r0),
        .in_g0      (in_g0),
        .in_b0      (in_b0),
        .in_r1      (in_r1),
        .in_g1      (in_g1),
        .in_b1      (in_b1),
        .out_valid  (out_valid),
        .out_y0     (out_y0),
        .out_cb0    (out_cb0),
        .out_cr0    (out_cr0),
        .out_y1     (out_y1),
        .out_cb1    (out_cb1),
        .out_cr1    (out_cr1),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {out_valid, out_sof, out_eol, out_eof, frame_done}
    task automatic chk_mk(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, out_valid, out_sof, out_eol, out_eof, frame_done}, {27'd0, exp});
    endtask

    // Send one beat, then 2 idle cycles; its output is visible afterwards.
    task automatic send_gap(input string tag, input logic [4:0] exp);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk_mk(tag, exp);
    endtask

    task automatic set_pix(input logic [7:0] r0, g0, b0, r1, g1, b1);
        in_r0 = r0; in_g0 = g0; in_b0 = b0;
        in_r1 = r1; in_g1 = g1; in_b1 = b1;
    endtask

    initial begin
        // ---------------- reset with in_valid held high
        HRESET = 1'b1; clr = 1'b0; in_valid = 1'b1;
        cfg_width = 12'd2; cfg_height = 12'd1;
        set_pix(8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0);
        tick(); tick(); tick();
        chk_mk("reset_markers", 5'b00000);
        chk("reset_y0", {24'd0, out_y0}, 32'd0);
        chk("reset_cb0_cr0", {16'd0, out_cb0, out_cr0}, 32'd0);
        chk("reset_lane1", {8'd0, out_y1, out_cb1, out_cr1}, 32'd0);
        chk("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);

        // ---------------- first beat after release: white / black, W=2 H=1
        HRESET = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        chk_mk("latency_2cyc_idle", 5'b00000);
        tick();
        chk_mk("white_black_mk", 5'b11111);
        chk("white_ycbcr", {8'd0, out_y0, out_cb0, out_cr0}, {8'd0, 8'd255, 8'd128, 8'd128});
        chk("black_ycbcr", {8'd0, out_y1, out_cb1, out_cr1}, {8'd0, 8'd0, 8'd128, 8'd128});
        chk("frame_cnt_1", {16'd0, frame_cnt}, 32'd1);

        // ---------------- red / blue, clamped chroma
        set_pix(8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255);
        send_gap("red_blue_mk", 5'b11111);
        chk("red_ycbcr", {8'd0, out_y0, out_cb0, out_cr0}, {8'd0, 8'd77, 8'd85, 8'd255});
        chk("blue_ycbcr", {8'd0, out_y1, out_cb1, out_cr1}, {8'd0, 8'd29, 8'd255, 8'd107});
        chk("frame_cnt_2", {16'd0, frame_cnt}, 32'd2);
        tick();
        chk_mk("idle_after_rb", 5'b00000);

        // ---------------- markers, W=4 H=2, back-to-back
        cfg_width = 12'd4; cfg_height = 12'd2;
        set_pix(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60);
        in_valid = 1'b1;
        tick(); tick(); tick();
        chk_mk("bb_b0", 5'b11000);
        tick();
        in_valid = 1'b0;
        chk_mk("bb_b1", 5'b10100);
        tick();
        chk_mk("bb_b2", 5'b10000);
        chk("bb_cnt_before", {16'd0, frame_cnt}, 32'd2);
        tick();
        chk_mk("bb_b3", 5'b10111);
        chk("bb_cnt_after", {16'd0, frame_cnt}, 32'd3);
        tick();
        chk_mk("bb_idle", 5'b00000);

        // ---------------- gaps, config change after beat 0
        send_gap("gap_b0", 5'b11000);
        cfg_width = 12'd8;
        send_gap("gap_b1", 5'b10100);
        send_gap("gap_b2", 5'b10000);
        send_gap("gap_b3", 5'b10111);
        chk("gap_cnt", {16'd0, frame_cnt}, 32'd4);

        // next frame picks up W=8
        for (int i = 0; i < 8; i++) begin
            send_gap($sformatf("w8_b%0d", i),
                     {1'b1, i == 0, (i == 3) || (i == 7), i == 7, i == 7});
        end
        chk("w8_cnt", {16'd0, frame_cnt}, 32'd5);

        // ---------------- clr mid-frame, W=4 H=2
        cfg_width = 12'd4; cfg_height = 12'd2;
        send_gap("clr_b0", 5'b11000);
        send_gap("clr_b1", 5'b10100);
        in_valid = 1'b1;           // beat 2, killed in flight by clr
        tick();
        clr = 1'b1;                // beat in the clr cycle is dropped
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        chk_mk("clr_flush_0", 5'b00000);
        tick();
        chk_mk("clr_flush_1", 5'b00000);
        tick();
        chk_mk("clr_flush_2", 5'b00000);
        chk("clr_cnt_kept", {16'd0, frame_cnt}, 32'd5);
        send_gap("clr_new_sof", 5'b11000);
        send_gap("clr_new_b1", 5'b10100);
        send_gap("clr_new_b2", 5'b10000);
        send_gap("clr_new_b3", 5'b10111);
        chk("clr_cnt_done", {16'd0, frame_cnt}, 32'd6);

        // ---------------- frame counter wrap
        cfg_width = 12'd2; cfg_height = 12'd1;
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        chk("wrap_preload", {16'd0, frame_cnt}, 32'h0000FFFF);
        send_gap("wrap_mk", 5'b11111);
        chk("wrap_cnt", {16'd0, frame_cnt}, 32'd0);
        tick();
        chk_mk("wrap_idle", 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
